// File: rtl/custom_fifo_rd_stream_if.sv
// Purpose : valid/ready stream bundle carrying data words plus a packet-end marker.
// Ports   : m_valid/m_data/m_last driven by the master, m_ready driven by the slave.
// Latency : none (wires only); backpressure: slave deasserts m_ready, master holds m_valid/m_data/m_last.
interface custom_fifo_rd_stream_if #(
  parameter int DATASIZE = 8
);
  logic                m_valid;
  logic                m_ready;
  logic [DATASIZE-1:0] m_data;
  logic                m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/custom_fifo_rd_stream.sv
// Purpose : read-side drain of an async FIFO into a 2-entry valid/ready buffer, framed into
//           PKT_LEN-beat packets, with a flush mode that discards and counts FIFO words.
// Latency : 1 cycle from FIFO pop to m_data; backpressure: m_ready only gates the registered
//           buffer count, so fifo_ren never depends combinationally on m_ready.
// Ports   : rclk_i/rrst_n_i clock and async active-low reset; fifo_empty/fifo_dout/fifo_ren
//           show-ahead FIFO read port; en_i stream enable; flush_i one-cycle flush request;
//           flush_busy_o/flush_drop_cnt flush status; m stream master (valid/ready/data/last).
module custom_fifo_rd_stream #(
  parameter int DATASIZE = 8,
  parameter int PKT_LEN  = 16,
  parameter int CNTW     = 16
) (
  input  logic                    rclk_i,
  input  logic                    rrst_n_i,
  input  logic                    fifo_empty,
  input  logic [DATASIZE-1:0]     fifo_dout,
  output logic                    fifo_ren,
  input  logic                    en_i,
  input  logic                    flush_i,
  output logic                    flush_busy_o,
  output logic [CNTW-1:0]         flush_drop_cnt,
  custom_fifo_rd_stream_if.master m
);

  // PKT_LEN=1 still needs a 1-bit counter so the port widths stay legal.
  localparam int            BW        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          count_q, count_d;
  logic [DATASIZE-1:0] ent0_q, ent0_d;
  logic [DATASIZE-1:0] ent1_q, ent1_d;
  logic [BW-1:0]       beat_cnt_q, beat_cnt_d;
  logic [CNTW-1:0]     drop_q, drop_d;

  logic push;      // popped word goes into the buffer (RUN only)
  logic hs;        // sink takes the buffer head this cycle
  logic flush_go;  // flush accepted this cycle

  // Pop decision uses only registered state/count plus fifo_empty.
  always_comb begin
    fifo_ren = 1'b0;
    unique case (state_q)
      RUN:     fifo_ren = !fifo_empty && (count_q < 2'd2);
      FLUSH:   fifo_ren = !fifo_empty;
      default: fifo_ren = 1'b0;
    endcase
  end

  assign push     = fifo_ren && (state_q == RUN);
  assign hs       = m.m_valid && m.m_ready;
  assign flush_go = flush_i && (state_q != FLUSH);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (flush_i) state_d = FLUSH; else if (en_i)  state_d = RUN;
      RUN:     if (flush_i) state_d = FLUSH; else if (!en_i) state_d = IDLE;
      FLUSH:   if (fifo_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Buffer: entry0 is the head. A handshake on the flush-entry cycle still completes at
  // the sink; the remaining entries are simply abandoned by clearing the count.
  always_comb begin
    count_d = count_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    if (flush_go) begin
      count_d = 2'd0;
    end else begin
      unique case ({push, hs})
        2'b10: begin
          if (count_q == 2'd0) ent0_d = fifo_dout;
          else                 ent1_d = fifo_dout;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          ent0_d  = ent1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous push and pop: shift and refill, count unchanged.
          if (count_q == 2'd1) begin
            ent0_d = fifo_dout;
          end else begin
            ent0_d = ent1_q;
            ent1_d = fifo_dout;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (flush_go)                       beat_cnt_d = '0;
    else if (hs && beat_cnt_q == LAST_BEAT) beat_cnt_d = '0;
    else if (hs)                        beat_cnt_d = beat_cnt_q + BW'(1);
  end

  // Drop counter counts only words popped while in FLUSH and saturates at all-ones.
  always_comb begin
    drop_d = drop_q;
    if (flush_go)
      drop_d = '0;
    else if ((state_q == FLUSH) && !fifo_empty && (drop_q != '1))
      drop_d = drop_q + CNTW'(1);
  end

  always_ff @(posedge rclk_i or negedge rrst_n_i) begin
    if (!rrst_n_i) begin
      state_q    <= IDLE;
      count_q    <= 2'd0;
      ent0_q     <= '0;
      ent1_q     <= '0;
      beat_cnt_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
      beat_cnt_q <= beat_cnt_d;
      drop_q     <= drop_d;
    end
  end

  assign m.m_valid      = (count_q != 2'd0);
  assign m.m_data       = ent0_q;
  assign m.m_last       = m.m_valid && (beat_cnt_q == LAST_BEAT);
  assign flush_busy_o   = (state_q == FLUSH);
  assign flush_drop_cnt = drop_q;

endmodule

// File: tb/tb_custom_fifo_rd_stream.sv
// Purpose : directed + randomized bench for custom_fifo_rd_stream with a show-ahead FIFO model
//           and an in-order scoreboard of expected beats and packet boundaries.
// Ports   : none; dut_a uses PKT_LEN=4/CNTW=16, dut_b uses PKT_LEN=1/CNTW=4.
module tb_custom_fifo_rd_stream;

  localparam int PKT_A = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Show-ahead FIFO models, one per DUT (index 0 -> dut_a, 1 -> dut_b).
  logic [7:0] fmem [2][256];
  int         fwr [2] = '{0, 0};
  int         frd [2] = '{0, 0};

  logic       en_a, en_b, flush_a, flush_b, rdy_a, rdy_b;
  logic       ren_a, ren_b, busy_a, busy_b;
  logic [15:0] drop_a;
  logic [3:0]  drop_b;
  logic       empty_a, empty_b;
  logic [7:0] dout_a, dout_b;

  assign empty_a = (fwr[0] == frd[0]);
  assign empty_b = (fwr[1] == frd[1]);
  assign dout_a  = fmem[0][frd[0] % 256];
  assign dout_b  = fmem[1][frd[1] % 256];

  always @(posedge clk) begin
    if (ren_a && !empty_a) frd[0] <= frd[0] + 1;
    if (ren_b && !empty_b) frd[1] <= frd[1] + 1;
  end

  custom_fifo_rd_stream_if #(.DATASIZE(8)) s_a ();
  custom_fifo_rd_stream_if #(.DATASIZE(8)) s_b ();
  assign s_a.m_ready = rdy_a;
  assign s_b.m_ready = rdy_b;

  custom_fifo_rd_stream #(.DATASIZE(8), .PKT_LEN(PKT_A), .CNTW(16)) dut_a (
    .rclk_i(clk), .rrst_n_i(rst_n), .fifo_empty(empty_a), .fifo_dout(dout_a),
    .fifo_ren(ren_a), .en_i(en_a), .flush_i(flush_a), .flush_busy_o(busy_a),
    .flush_drop_cnt(drop_a), .m(s_a));

  custom_fifo_rd_stream #(.DATASIZE(8), .PKT_LEN(1), .CNTW(4)) dut_b (
    .rclk_i(clk), .rrst_n_i(rst_n), .fifo_empty(empty_b), .fifo_dout(dout_b),
    .fifo_ren(ren_b), .en_i(en_b), .flush_i(flush_b), .flush_busy_o(busy_b),
    .flush_drop_cnt(drop_b), .m(s_b));

  int         passed = 0;
  int         total  = 0;
  logic [7:0] expq [$];   // words dut_a must deliver, in order
  int         idx_a = 0;  // beats delivered since the last framing restart

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) passed++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, want);
  endtask

  task automatic push(input int s, input logic [7:0] d, input bit track);
    fmem[s][fwr[s] % 256] = d;
    fwr[s]++;
    if (track) expq.push_back(d);
  endtask

  // One cycle on dut_a: drive m_ready at the falling edge and score any handshake that
  // will complete at the next rising edge.
  task automatic step_a(input bit r);
    @(negedge clk);
    rdy_a = r;
    #1;
    if (s_a.m_valid && rdy_a) begin
      check("beat_avail", 32'(expq.size() != 0), 1);
      if (expq.size() != 0) begin
        check("beat_data", s_a.m_data, expq.pop_front());
        check("beat_last", s_a.m_last, 32'((idx_a % PKT_A) == PKT_A - 1));
        idx_a++;
      end
    end
  endtask

  task automatic drain_a(input string tag, input bit rand_rdy);
    for (int i = 0; i < 300 && expq.size() != 0; i++)
      step_a(rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    check(tag, expq.size(), 0);
  endtask

  initial begin
    int r0, ed, k;
    bit exp_ren [5] = '{1, 1, 1, 0, 0};
    bit exp_val [5] = '{0, 1, 1, 1, 0};

    rst_n = 1'b0; en_a = 1'b1; en_b = 1'b1;
    flush_a = 1'b0; flush_b = 1'b0; rdy_a = 1'b1; rdy_b = 1'b0;
    for (int i = 0; i < 3; i++) push(0, 8'hA0 + 8'(i), 1'b1);
    repeat (2) @(negedge clk);
    #1;
    // Reset state: FIFO non-empty and en_i high, yet nothing may pop or show.
    check("rst_valid", s_a.m_valid, 0);
    check("rst_data", s_a.m_data, 0);
    check("rst_last", s_a.m_last, 0);
    check("rst_ren", ren_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_drop", drop_a, 0);

    // Three words, sink always ready: three pops, data one cycle behind.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step_a(1'b1);
      check($sformatf("t1_ren%0d", i), ren_a, 32'(exp_ren[i]));
      check($sformatf("t1_val%0d", i), s_a.m_valid, 32'(exp_val[i]));
    end

    // Five words, sink stalled: exactly two pops, head held stable.
    rdy_a = 1'b0;
    r0 = frd[0];
    for (int i = 0; i < 5; i++) push(0, 8'hB0 + 8'(i), 1'b1);
    repeat (6) step_a(1'b0);
    check("t2_pops", frd[0] - r0, 2);
    for (int i = 0; i < 3; i++) begin
      step_a(1'b0);
      check("t2_hold_valid", s_a.m_valid, 1);
      check("t2_hold_data", s_a.m_data, 8'hB0);
    end
    drain_a("t2_drain", 1'b0);
    check("t2_all_pops", frd[0] - r0, 5);

    // Ten random words with random m_ready; framing starts this group at a packet boundary.
    check("t3_aligned", idx_a % PKT_A, 0);
    for (int i = 0; i < 10; i++) push(0, 8'($urandom), 1'b1);
    drain_a("t3_drain", 1'b1);
    step_a(1'b0);
    check("t3_beat_cnt", dut_a.beat_cnt_q, idx_a % PKT_A);

    // IDLE: no pops even though words are waiting.
    en_a = 1'b0;
    step_a(1'b0);
    r0 = frd[0];
    for (int i = 0; i < 3; i++) push(0, 8'hC0 + 8'(i), 1'b1);
    repeat (5) step_a(1'b1);
    check("idle_no_pop", frd[0] - r0, 0);
    check("idle_valid", s_a.m_valid, 0);

    // Buffer full (2), 20 words left in the FIFO, then flush.
    en_a = 1'b1;
    repeat (4) step_a(1'b0);
    for (int i = 0; i < 19; i++) push(0, 8'hD0 + 8'(i), 1'b0);
    repeat (2) step_a(1'b0);
    check("t4_pre_valid", s_a.m_valid, 1);
    r0 = frd[0];
    ed = fwr[0] - frd[0];
    @(negedge clk);
    flush_a = 1'b1;
    @(negedge clk);
    flush_a = 1'b0;
    #1;
    expq.delete();
    idx_a = 0;
    check("t4_valid_off", s_a.m_valid, 0);
    check("t4_busy_on", busy_a, 1);
    for (int i = 0; i < 100; i++) begin
      if (!busy_a) break;
      @(negedge clk);
      #1;
    end
    check("t4_busy_off", busy_a, 0);
    check("t4_empty", empty_a, 1);
    check("t4_pops", frd[0] - r0, ed);
    check("t4_drop", drop_a, (ed > 65535) ? 65535 : ed);
    check("t4_beat_cnt", dut_a.beat_cnt_q, 0);
    for (int i = 0; i < 4; i++) push(0, 8'hE0 + 8'(i), 1'b1);
    drain_a("t4_post_drain", 1'b0);
    check("t4_drop_hold", drop_a, (ed > 65535) ? 65535 : ed);

    // Reset mid-packet with two buffered words and one left in the FIFO.
    for (int i = 0; i < 2; i++) push(0, 8'h90 + 8'(i), 1'b1);
    drain_a("t6_pre_drain", 1'b0);
    step_a(1'b0);
    for (int i = 0; i < 3; i++) push(0, 8'h80 + 8'(i), 1'b1);
    repeat (4) step_a(1'b0);
    check("t6_pre_valid", s_a.m_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t6_valid", s_a.m_valid, 0);
    check("t6_data", s_a.m_data, 0);
    check("t6_last", s_a.m_last, 0);
    check("t6_ren", ren_a, 0);
    check("t6_busy", busy_a, 0);
    check("t6_drop", drop_a, 0);
    // Buffered words are lost; whatever is still in the FIFO is delivered next.
    expq.delete();
    for (int p = frd[0]; p < fwr[0]; p++) expq.push_back(fmem[0][p % 256]);
    idx_a = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) push(0, 8'hF0 + 8'(i), 1'b1);
    drain_a("t6_drain", 1'b0);

    // dut_b: PKT_LEN=1 marks every beat last; CNTW=4 saturates the drop count.
    @(negedge clk);
    for (int i = 0; i < 3; i++) push(1, 8'h31 + 8'(i), 1'b0);
    k = 0;
    for (int i = 0; i < 20 && k < 3; i++) begin
      @(negedge clk);
      rdy_b = 1'b1;
      #1;
      if (s_b.m_valid) begin
        check("b_last", s_b.m_last, 1);
        check("b_data", s_b.m_data, 8'h31 + 8'(k));
        k++;
      end
    end
    check("b_beats", k, 3);
    @(negedge clk);
    rdy_b = 1'b0;
    for (int i = 0; i < 22; i++) push(1, 8'h40 + 8'(i), 1'b0);
    repeat (6) @(negedge clk);
    r0 = frd[1];
    ed = fwr[1] - frd[1];
    @(negedge clk);
    flush_b = 1'b1;
    @(negedge clk);
    flush_b = 1'b0;
    #1;
    check("b_valid_off", s_b.m_valid, 0);
    for (int i = 0; i < 100; i++) begin
      if (!busy_b) break;
      @(negedge clk);
      #1;
    end
    check("b_busy_off", busy_b, 0);
    check("b_pops", frd[1] - r0, ed);
    check("b_drop_sat", drop_b, (ed > 15) ? 15 : ed);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
